// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_CPU  = 2'b01,
    DBG_LOCK = 2'b10
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int   STAT_W   = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_r;

  // counter register, holds at MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && !sat) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign sat   = (count_r == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU and a debug/DMA requester.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_conflicts,
  output logic [STAT_W-1:0] stat_forced
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_s;
  logic              wait_sat_s;
  logic [LOCK_W-1:0] lock_cnt_s;
  logic              lock_sat_s;
  logic              cpu_gnt_s;
  logic              dbg_gnt_s;
  logic              forced_s;
  logic              lock_inc_s;
  logic              lock_clr_s;
  logic              last_beat_s;
  logic              any_gnt_s;
  logic              gnt_port_s;
  logic              dbg_rd_s;
  logic [DATA_W-1:0] dbg_rdata_r;
  logic              dbg_valid_r;

  // A granted beat at lock_cnt==MAX_LOCK-1 is the last one the burst may take
  assign last_beat_s = (lock_cnt_s == LOCK_W'(MAX_LOCK - 1)) | lock_sat_s;

  // grant select and next state
  always_comb begin
    cpu_gnt_s   = 1'b0;
    dbg_gnt_s   = 1'b0;
    forced_s    = 1'b0;
    lock_inc_s  = 1'b0;
    lock_clr_s  = 1'b0;
    state_nxt_s = state_r;
    if (reset) begin
      state_nxt_s = OWN_CPU;
      lock_clr_s  = 1'b1;
    end else begin
      case (state_r)
        OWN_CPU: begin
          forced_s = dbg_req & (wait_cnt_s == WAIT_W'(MAX_WAIT));
          if (forced_s || (dbg_req && !cpu_req)) begin
            dbg_gnt_s = 1'b1;
            if (dbg_lock && !last_beat_s) begin
              state_nxt_s = DBG_LOCK;
              lock_inc_s  = 1'b1;
            end else begin
              lock_clr_s = 1'b1;
            end
          end else begin
            cpu_gnt_s  = cpu_req;
            lock_clr_s = 1'b1;
          end
        end
        DBG_LOCK: begin
          if (dbg_req) begin
            dbg_gnt_s = 1'b1;
            if (!dbg_lock || last_beat_s) begin
              state_nxt_s = OWN_CPU;
              lock_clr_s  = 1'b1;
            end else begin
              lock_inc_s = 1'b1;
            end
          end else begin
            state_nxt_s = OWN_CPU;
            lock_clr_s  = 1'b1;
          end
        end
        default: begin
          state_nxt_s = OWN_CPU;
          lock_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // arbitration state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= OWN_CPU;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  arb_sat_counter #(.W(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dbg_req & ~dbg_gnt_s & ~wait_sat_s),
    .clr   (dbg_gnt_s),
    .count (wait_cnt_s),
    .sat   (wait_sat_s)
  );

  arb_sat_counter #(.W(LOCK_W), .MAX(MAX_LOCK)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lock_inc_s & ~lock_sat_s),
    .clr   (lock_clr_s),
    .count (lock_cnt_s),
    .sat   (lock_sat_s)
  );

  assign any_gnt_s  = cpu_gnt_s | dbg_gnt_s;
  assign gnt_port_s = dbg_gnt_s ? PORT_DBG : PORT_CPU;

  // memory port mux; idle port parks on the CPU address with writes off
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (any_gnt_s) begin
      if (gnt_port_s == PORT_DBG) begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we;
      end else begin
        mem_we = cpu_we;
      end
    end else begin
      mem_we = 1'b0;
    end
  end

  assign dbg_rd_s = dbg_gnt_s & ~dbg_we;

  // debug read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_valid_r <= 1'b0;
      dbg_rdata_r <= '0;
    end else begin
      dbg_valid_r <= dbg_rd_s;
      if (dbg_rd_s) begin
        dbg_rdata_r <= mem_rdata;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = cpu_req & ~cpu_gnt_s & ~reset;
  assign dbg_gnt   = dbg_gnt_s;
  assign dbg_rdata = dbg_rdata_r;
  assign dbg_valid = dbg_valid_r;

`ifdef DMEM_ARB_STATS_EN
  logic conf_sat_s;
  logic forced_sat_s;

  arb_sat_counter #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_conflicts (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_req & dbg_req & ~conf_sat_s),
    .clr   (1'b0),
    .count (stat_conflicts),
    .sat   (conf_sat_s)
  );

  arb_sat_counter #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_forced (
    .clk   (clk),
    .reset (reset),
    .inc   (forced_s & dbg_gnt_s & ~forced_sat_s),
    .clr   (1'b0),
    .count (stat_forced),
    .sat   (forced_sat_s)
  );
`else
  assign stat_conflicts = '0;
  assign stat_forced    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_gnt, dbg_valid;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] stat_conflicts, stat_forced;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
  );

  // data memory the arbiter drives: comb read, sync write
  logic [31:0] ram [0:63] = '{default: 32'h0};
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] ref_mem [0:63];
  int          m_wait = 0, m_beats = 0, m_conf = 0, m_forced = 0;
  bit          m_burst = 1'b0, m_valid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  bit          last_c = 1'b0, last_d = 1'b0;
  int          obs_stall = 0, obs_dgnt = 0;
  logic        obs_we = 1'b0, obs_gnt = 1'b0;
  logic [7:0]  obs_addr = 8'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input bit cr, input bit cw, input logic [7:0] ca, input logic [31:0] cd,
                     input bit dr, input bit dw, input bit dl, input logic [7:0] da,
                     input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
  endtask

  // one clock: check outputs mid-cycle against the model, advance the model, cross the edge
  task automatic step();
    bit          gc, gd, fz, ewe;
    logic [7:0]  ea;
    logic [31:0] ed;
    #4;
    gc = 1'b0; gd = 1'b0; fz = 1'b0;
    if (!reset) begin
      if (m_burst) gd = dbg_req;
      else if (dbg_req && (m_wait >= MAX_WAIT || !cpu_req)) begin
        gd = 1'b1;
        fz = (m_wait >= MAX_WAIT);
      end else gc = cpu_req;
    end
    ewe = gc ? cpu_we : (gd ? dbg_we : 1'b0);
    ea  = gd ? dbg_addr : cpu_addr;
    ed  = gd ? dbg_wdata : cpu_wdata;
    check_eq("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !gc && !reset));
    check_eq("dbg_gnt", 32'(dbg_gnt), 32'(gd));
    check_eq("mem_we", 32'(mem_we), 32'(ewe));
    check_eq("mem_addr", 32'(mem_addr), 32'(ea));
    if (ewe) check_eq("mem_wdata", mem_wdata, ed);
    if (gc && !cpu_we) check_eq("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:2]]);
    check_eq("dbg_valid", 32'(dbg_valid), 32'(m_valid));
    check_eq("dbg_rdata", dbg_rdata, m_rdata);
`ifdef DMEM_ARB_STATS_EN
    check_eq("stat_conflicts", 32'(stat_conflicts), 32'(m_conf));
    check_eq("stat_forced", 32'(stat_forced), 32'(m_forced));
`else
    check_eq("stat_conflicts", 32'(stat_conflicts), 32'h0);
    check_eq("stat_forced", 32'(stat_forced), 32'h0);
`endif
    obs_stall += int'(cpu_stall);
    obs_dgnt  += int'(dbg_gnt);
    obs_we = mem_we; obs_gnt = dbg_gnt; obs_addr = mem_addr;
    if (reset) begin
      m_valid = 1'b0; m_rdata = 32'h0; m_wait = 0; m_burst = 1'b0; m_beats = 0;
      m_conf = 0; m_forced = 0;
    end else begin
      m_valid = gd && !dbg_we;
      if (m_valid) m_rdata = ref_mem[dbg_addr[7:2]];
      if (ewe) ref_mem[ea[7:2]] = ed;
      if (cpu_req && dbg_req && m_conf < 65535) m_conf++;
      if (fz && m_forced < 65535) m_forced++;
      if (gd) m_wait = 0;
      else if (dbg_req && m_wait < MAX_WAIT) m_wait++;
      if (m_burst) begin
        if (!dbg_req) begin
          m_burst = 1'b0; m_beats = 0;
        end else begin
          m_beats++;
          if (!dbg_lock || m_beats >= MAX_LOCK) begin m_burst = 1'b0; m_beats = 0; end
        end
      end else if (gd && dbg_lock) begin
        m_beats = 1;
        m_burst = (m_beats < MAX_LOCK);
        if (!m_burst) m_beats = 0;
      end
    end
    last_c = gc; last_d = gd;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    drv(0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    int first, s0, g0, beats;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    reset = 1'b1;
    drv(1, 1, 8'h54, 32'd9, 1, 1, 0, 8'h10, 32'h1);
    @(posedge clk);
    #1;
    // requests during reset must not reach the memory
    step();
    check_eq("rst_mem_we", 32'(obs_we), 32'h0);
    check_eq("rst_dbg_valid", 32'(dbg_valid), 32'h0);
    check_eq("rst_dbg_rdata", dbg_rdata, 32'h0);
    reset = 1'b0;

    // CPU alone
    drv(1, 1, 8'h54, 32'd7, 0, 0, 0, 8'h0, 32'h0);
    step();
    check_eq("s1_mem_we", 32'(obs_we), 32'h1);
    check_eq("s1_mem_addr", 32'(obs_addr), 32'h54);

    // contention: CPU wins MAX_WAIT cycles, then debug is forced
    reset_cycle();
    drv(1, 0, 8'h04, 32'h0, 1, 0, 0, 8'h50, 32'h0);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (obs_gnt && first == 0) first = i;
    end
    check_eq("s2_first_dgnt", 32'(first), 32'd5);
`ifdef DMEM_ARB_STATS_EN
    check_eq("s2_conflicts", 32'(stat_conflicts), 32'd8);
    check_eq("s2_forced", 32'(stat_forced), 32'd1);
`else
    check_eq("s2_conflicts", 32'(stat_conflicts), 32'd0);
    check_eq("s2_forced", 32'(stat_forced), 32'd0);
`endif

    // debug alone: write then read back
    drv(0, 0, 8'h0, 32'h0, 1, 1, 0, 8'h10, 32'hDEADBEEF);
    step();
    drv(0, 0, 8'h0, 32'h0, 1, 0, 0, 8'h10, 32'h0);
    step();
    check_eq("s3_valid", 32'(dbg_valid), 32'h1);
    check_eq("s3_rdata", dbg_rdata, 32'hDEADBEEF);
    drv(0, 0, 8'h0, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    step();

    // 3-beat locked burst against a held CPU request
    reset_cycle();
    s0 = obs_stall; beats = 0;
    for (int i = 0; i < 20 && beats < 3; i++) begin
      drv(1, 0, 8'h08, 32'h0, 1, 1, (beats < 2), 8'h20 + 8'(4 * beats), 32'h100 + 32'(beats));
      step();
      if (last_d) beats++;
    end
    check_eq("s4_stalls", 32'(obs_stall - s0), 32'd3);
    drv(1, 0, 8'h08, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    step();

    // 10-beat lock request is cut at MAX_LOCK
    reset_cycle();
    s0 = obs_stall; g0 = obs_dgnt;
    drv(0, 0, 8'h0C, 32'h0, 1, 0, 1, 8'h20, 32'h0);
    step();
    cpu_req = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_eq("s4_lock_beats", 32'(obs_dgnt - g0), 32'd8);
    check_eq("s4_lock_stalls", 32'(obs_stall - s0), 32'd7);

    // reset lands on beat 2 of a burst
    reset_cycle();
    drv(0, 0, 8'h0, 32'h0, 1, 0, 1, 8'h10, 32'h0);
    step();
    drv(0, 0, 8'h0, 32'h0, 1, 1, 1, 8'h30, 32'h55AA55AA);
    reset = 1'b1;
    step();
    check_eq("s5_mem_we", 32'(obs_we), 32'h0);
    check_eq("s5_dbg_gnt", 32'(obs_gnt), 32'h0);
    reset = 1'b0;
    check_eq("s5_dbg_valid", 32'(dbg_valid), 32'h0);
    drv(1, 0, 8'h30, 32'h0, 0, 0, 0, 8'h0, 32'h0);
    step();

    // random traffic; stalled CPU and ungranted debug hold their request
    for (int n = 0; n < 3000; n++) begin
      if (!(cpu_req && !last_c)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 8'($urandom);
        cpu_wdata = $urandom;
      end
      if (!(dbg_req && !last_d)) begin
        dbg_req   = ($urandom_range(0, 99) < 45);
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_lock  = ($urandom_range(0, 99) < 70);
        dbg_addr  = 8'($urandom);
        dbg_wdata = $urandom;
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
